// File: rtl/common_types_pkg.sv
// common_types_pkg -- shared types for the memory arbiter slice.
//   ram_state_t : status reported by the RAM; RAM_DONE marks the completing cycle.
//   arb_state_t : arbiter FSM states.
//   onehot_any  : helper used to flag a non-empty request or enable vector.
package common_types_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_BUSY = 2'd1,
    RAM_DONE = 2'd2,
    RAM_ERR  = 2'd3
  } ram_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // True when any bit of an 8-bit vector is set.
  function automatic logic onehot_any(input logic [7:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/arb_select.sv
// arb_select -- rotating fixed-priority picker.
//   req   : request vector, one bit per port
//   ptr   : index of the highest-priority port for this decision
//   grant : one-hot grant (all zero when nothing is requesting)
// The request vector is rotated so that port ptr lands at bit 0, a plain
// lowest-index-wins pick is made, and the result is rotated back.
module arb_select #(
  parameter int NPORTS = 3,
  parameter int PTR_W  = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NPORTS-1:0] grant
);

  logic [2*NPORTS-1:0] dbl_req_s;
  logic [2*NPORTS-1:0] dbl_gnt_s;
  logic [NPORTS-1:0]   rot_req_s;
  logic [NPORTS-1:0]   rot_gnt_s;
  logic                found_s;

  // Rotate, pick lowest set bit, rotate back.
  always_comb begin
    dbl_req_s = {req, req} >> ptr;
    rot_req_s = dbl_req_s[NPORTS-1:0];
    rot_gnt_s = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rot_req_s[i] && !found_s) begin
        rot_gnt_s[i] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    dbl_gnt_s = {rot_gnt_s, rot_gnt_s} << ptr;
    grant     = dbl_gnt_s[2*NPORTS-1:NPORTS];
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates NPORTS requesters onto a single RAM port.
//   clk, nrst               : clock, synchronous active-low reset
//   req_ren/wen/addr/store  : per-port request (write wins over read)
//   req_wait                : per-port stall, low only in the completing cycle
//   req_load                : RAM read data broadcast to every port
//   ram_ren/wen/addr/store  : RAM request, driven from the granted port in BUSY
//   ram_state, ram_load     : RAM status and read data
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with port 0 highest and no pointer register.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [NPORTS-1:0]                   req_ren,
  input  logic [NPORTS-1:0][DATA_W/8-1:0]     req_wen,
  input  logic [NPORTS-1:0][ADDR_W-1:0]       req_addr,
  input  logic [NPORTS-1:0][DATA_W-1:0]       req_store,
  output logic [NPORTS-1:0]                   req_wait,
  output logic [DATA_W-1:0]                   req_load,
  output logic                                ram_ren,
  output logic [DATA_W/8-1:0]                 ram_wen,
  output logic [ADDR_W-1:0]                   ram_addr,
  output logic [DATA_W-1:0]                   ram_store,
  input  ram_state_t                          ram_state,
  input  logic [DATA_W-1:0]                   ram_load
);

  localparam int WEN_W = DATA_W / 8;
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_t        state_r;
  logic [NPORTS-1:0] grant_r;
  logic [NPORTS-1:0] req_s;
  logic [NPORTS-1:0] sel_s;
  logic [PTR_W-1:0]  ptr_s;
  logic              gnt_req_s;
  logic              active_s;
  logic              done_s;
  logic              mux_ren_s;
  logic [WEN_W-1:0]  mux_wen_s;
  logic [ADDR_W-1:0] mux_addr_s;
  logic [DATA_W-1:0] mux_store_s;

  // Per-port request detect and AND-OR mux of the granted port's inputs.
  always_comb begin
    req_s       = '0;
    mux_ren_s   = 1'b0;
    mux_wen_s   = '0;
    mux_addr_s  = '0;
    mux_store_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      req_s[i]    = req_ren[i] | (|req_wen[i]);
      mux_ren_s   = mux_ren_s | (req_ren[i] & grant_r[i]);
      mux_wen_s   = mux_wen_s | (req_wen[i] & {WEN_W{grant_r[i]}});
      mux_addr_s  = mux_addr_s | (req_addr[i] & {ADDR_W{grant_r[i]}});
      mux_store_s = mux_store_s | (req_store[i] & {DATA_W{grant_r[i]}});
    end
  end

  arb_select #(
    .NPORTS (NPORTS),
    .PTR_W  (PTR_W)
  ) u_arb_select (
    .req   (req_s),
    .ptr   (ptr_s),
    .grant (sel_s)
  );

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] sel_idx_s;

  // One-hot to index of the port being granted this cycle.
  always_comb begin
    sel_idx_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      sel_idx_s = sel_idx_s | (sel_s[i] ? PTR_W'(i) : '0);
    end
  end

  // Search start: one past the last granted port, wrapping at NPORTS.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr_r <= '0;
    end else if (state_r == IDLE && (|req_s)) begin
      ptr_r <= (sel_idx_s == PTR_W'(NPORTS - 1)) ? '0 : sel_idx_s + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  // A granted port that withdraws its request kills the strobes immediately.
  assign gnt_req_s = |(grant_r & req_s);
  assign active_s  = (state_r == BUSY) && nrst && gnt_req_s;
  assign done_s    = active_s && (ram_state == RAM_DONE);

  assign ram_wen   = active_s ? mux_wen_s : '0;
  assign ram_ren   = active_s & mux_ren_s & ~(|mux_wen_s);
  assign ram_addr  = active_s ? mux_addr_s : '0;
  assign ram_store = active_s ? mux_store_s : '0;
  assign req_wait  = ~(grant_r & {NPORTS{done_s}});
  assign req_load  = ram_load;

  // Arbiter FSM: grant in IDLE, hold the grant until done or withdrawn.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= IDLE;
      grant_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_s) begin
            state_r <= BUSY;
            grant_r <= sel_s;
          end else begin
            state_r <= IDLE;
            grant_r <= '0;
          end
        end
        BUSY: begin
          if (done_s || !gnt_req_s) begin
            state_r <= IDLE;
            grant_r <= '0;
          end else begin
            state_r <= BUSY;
            grant_r <= grant_r;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; WEN_W = DATA_W/8 byte enables.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-005 Port list SHALL be:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- req_ren  in  NPORTS  per-port read request.
- req_wen  in  NPORTS x WEN_W  per-port byte write enables.
- req_addr  in  NPORTS x ADDR_W  per-port address.
- req_store  in  NPORTS x DATA_W  per-port write data.
- req_wait  out  NPORTS  per-port stall; low for exactly the completing cycle.
- req_load  out  DATA_W  read data broadcast to all ports.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  WEN_W  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_state  in  ram_state_t  RAM status; RAM_DONE marks completion.
- ram_load  in  DATA_W  RAM read data.

Function
REQ-006 A port SHALL be requesting when req_ren or any req_wen bit is high; when both are set, the write wins.
REQ-007 FSM states SHALL be IDLE and BUSY.
REQ-008 In IDLE, any request present SHALL register a one-hot grant and move to BUSY on the next edge; RAM outputs SHALL stay zero while IDLE.
REQ-009 In BUSY, ram_addr, ram_store, ram_ren and ram_wen SHALL be driven combinationally from the granted port's current inputs.
REQ-010 In BUSY, when ram_state==RAM_DONE, req_wait of the granted port SHALL be low in that same cycle.
REQ-011 On the same RAM_DONE edge, the FSM SHALL return to IDLE; arbitration latency is therefore 1 cycle per transaction.
REQ-012 In BUSY, if the granted port drops its request before RAM_DONE, RAM strobes SHALL go zero that cycle and the FSM SHALL return to IDLE next edge, with no wait release.
REQ-013 The grant SHALL be locked in BUSY; requests from other ports SHALL NOT preempt it.
REQ-014 req_wait SHALL be high for every non-granted port in every cycle.
REQ-015 req_load SHALL equal ram_load at all times; the wait release qualifies validity.
REQ-016 Simultaneous requests SHALL be resolved per the arbitration policy (REQ-019/020).
REQ-017 The arbiter SHALL insert no bubble beyond the single IDLE cycle between back-to-back grants.

Reset
REQ-018 While nrst is low at a clock edge:
- FSM SHALL go to IDLE and the grant SHALL clear.
- Round-robin pointer SHALL reset to port 0.
- All RAM outputs SHALL be 0 and all req_wait SHALL be 1, including when reset arrives mid-transaction.

Configuration
REQ-019 With macro MEM_ARB_RR_EN defined, the policy SHALL be round-robin: search starts at last_grant+1 modulo NPORTS, and last_grant updates on each grant.
REQ-020 Without MEM_ARB_RR_EN, the policy SHALL be fixed priority with the lowest index highest, and no pointer register exists.

Structure
REQ-021 ram_state_t (incl. RAM_DONE) and arb_state_t {IDLE,BUSY} SHALL live in common_types_pkg.
REQ-022 Arbitration logic SHALL be one sub-module, arb_select (request vector + pointer -> one-hot grant), instantiated once.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single port 1 read of addr 0x100, RAM_DONE after 3 cycles -> ram_addr=0x100, ram_ren=1 in BUSY; req_wait[1] low exactly one cycle; req_load=ram_load.
- Ports 0 and 2 both write at once (fixed priority) -> port 0 served first (ram_wen=4'hF); port 2 granted after one IDLE cycle.
- Ports 0,1,2 continuously reading (MEM_ARB_RR_EN) -> grant order 0,1,2,0,1,2; no port is starved.
- Port 1 sets req_ren=1 and req_wen=4'h3 together -> ram_wen=4'h3, ram_ren=0.
- Port 0 drops its request mid-BUSY -> RAM strobes are zero that cycle; IDLE next cycle; req_wait[0] never goes low.
- nrst low during BUSY -> next cycle: IDLE, all outputs zero, all waits high; the round-robin pointer restarts at port 0.
